// File: rtl/serial_adc_reader.sv
// serial_adc_reader: CS-framed serial SAR-ADC capture engine.
// Drives a shared CSN/SCLK pair to NUM_CH converters and captures their
// SDATA lines in lockstep, one parallel word per channel per frame.
// Leading zero bits are checked and flagged, not delivered.
module serial_adc_reader #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned LEAD_BITS = 2,
  parameter int unsigned SCLK_HALF = 1,
  parameter int unsigned QUIET     = 4,
  parameter int unsigned NUM_CH    = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     cont_en,
  input  logic                     start,
  output logic                     adc_csn,
  output logic                     adc_sclk,
  input  logic [NUM_CH-1:0]        adc_sdata,
  output logic                     busy,
  output logic                     adc_data_en,
  output logic [NUM_CH*DATA_W-1:0] adc_data,
  output logic [NUM_CH-1:0]        lead_err
);

  localparam int unsigned N      = LEAD_BITS + DATA_W;
  localparam int unsigned PHASES = 2 * N;
  localparam int unsigned HALF_W = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int unsigned PH_W   = $clog2(PHASES);
  localparam int unsigned Q_W    = (QUIET > 1) ? $clog2(QUIET) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_QUIET  = 2'd2
  } state_t;

  state_t                          state;
  logic [HALF_W-1:0]               half_cnt;
  logic [PH_W-1:0]                 phase_cnt;
  logic [Q_W-1:0]                  quiet_cnt;
  logic [NUM_CH-1:0][DATA_W-1:0]   shreg;
  logic [NUM_CH-1:0]               lead_acc;
  logic                            half_done_c;
  logic                            quiet_done_c;
  logic                            enter_active_c;

  // Frame-level decode: end of SCLK half-period, end of quiet gap, frame launch
  always_comb begin
    half_done_c    = 1'b0;
    quiet_done_c   = 1'b0;
    enter_active_c = 1'b0;
    half_done_c    = (half_cnt == HALF_W'(SCLK_HALF - 1));
    quiet_done_c   = (quiet_cnt == Q_W'(QUIET - 1));
    enter_active_c = ((state == ST_IDLE) && (cont_en || start)) ||
                     ((state == ST_QUIET) && quiet_done_c && cont_en);
  end

  // Capture FSM: SCLK generation, sampling on SCLK fall, delivery on frame end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      adc_csn     <= 1'b1;
      adc_sclk    <= 1'b1;
      busy        <= 1'b0;
      adc_data_en <= 1'b0;
      adc_data    <= '0;
      lead_err    <= '0;
      half_cnt    <= '0;
      phase_cnt   <= '0;
      quiet_cnt   <= '0;
      shreg       <= '0;
      lead_acc    <= '0;
    end else begin
      adc_data_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          adc_csn  <= 1'b1;
          adc_sclk <= 1'b1;
        end
        ST_ACTIVE: begin
          if (half_done_c) begin
            half_cnt <= '0;
            if (phase_cnt == PH_W'(PHASES - 1)) begin
              // Last low half-period done: release the bus and deliver
              state       <= ST_QUIET;
              adc_csn     <= 1'b1;
              adc_sclk    <= 1'b1;
              phase_cnt   <= '0;
              quiet_cnt   <= '0;
              adc_data    <= shreg;
              lead_err    <= lead_acc;
              adc_data_en <= 1'b1;
            end else begin
              phase_cnt <= phase_cnt + PH_W'(1);
              adc_sclk  <= ~adc_sclk;
              if (adc_sclk) begin
                // Falling SCLK edge: even phases index the frame bit
                if (phase_cnt < PH_W'(2 * LEAD_BITS)) begin
                  lead_acc <= lead_acc | adc_sdata;
                end else begin
                  for (int c = 0; c < NUM_CH; c++) begin
                    shreg[c] <= (shreg[c] << 1) | DATA_W'(adc_sdata[c]);
                  end
                end
              end
            end
          end else begin
            half_cnt <= half_cnt + HALF_W'(1);
          end
        end
        ST_QUIET: begin
          if (quiet_done_c) begin
            quiet_cnt <= '0;
            if (!cont_en) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            quiet_cnt <= quiet_cnt + Q_W'(1);
          end
        end
        default: begin
          state   <= ST_IDLE;
          adc_csn <= 1'b1;
          busy    <= 1'b0;
        end
      endcase

      // Launch a frame: fresh counters, shift registers and accumulators
      if (enter_active_c) begin
        state     <= ST_ACTIVE;
        adc_csn   <= 1'b0;
        adc_sclk  <= 1'b1;
        busy      <= 1'b1;
        half_cnt  <= '0;
        phase_cnt <= '0;
        quiet_cnt <= '0;
        shreg     <= '0;
        lead_acc  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_adc_reader.sv
// Bench for serial_adc_reader: default single-channel instance plus a
// 3-channel instance, each fed by a behavioural AD7276-style converter model.
module tb_serial_adc_reader;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // Instance A: defaults (DATA_W=12, LEAD_BITS=2, SCLK_HALF=1, QUIET=4, NUM_CH=1)
  logic        a_cont_en, a_start, a_csn, a_sclk, a_busy, a_data_en;
  logic [0:0]  a_sdata;
  logic [11:0] a_data;
  logic [0:0]  a_lead_err;

  // Instance B: NUM_CH=3, DATA_W=10, LEAD_BITS=3, SCLK_HALF=2
  logic        b_cont_en, b_start, b_csn, b_sclk, b_busy, b_data_en;
  logic [2:0]  b_sdata;
  logic [29:0] b_data;
  logic [2:0]  b_lead_err;

  serial_adc_reader u_dut_a (
    .clk(clk), .rstn(rstn), .cont_en(a_cont_en), .start(a_start),
    .adc_csn(a_csn), .adc_sclk(a_sclk), .adc_sdata(a_sdata),
    .busy(a_busy), .adc_data_en(a_data_en), .adc_data(a_data),
    .lead_err(a_lead_err)
  );

  serial_adc_reader #(
    .DATA_W(10), .LEAD_BITS(3), .SCLK_HALF(2), .QUIET(4), .NUM_CH(3)
  ) u_dut_b (
    .clk(clk), .rstn(rstn), .cont_en(b_cont_en), .start(b_start),
    .adc_csn(b_csn), .adc_sclk(b_sclk), .adc_sdata(b_sdata),
    .busy(b_busy), .adc_data_en(b_data_en), .adc_data(b_data),
    .lead_err(b_lead_err)
  );

  int checks = 0;
  int errors = 0;

  // Single comparison point for the whole bench
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Converter model A: bit 0 on CS fall, next bit after each SCLK fall
  logic [13:0] fw_a;
  int          idx_a = 0;
  always @(negedge a_csn or negedge a_sclk) begin
    if (a_sclk) idx_a = 0;
    else        idx_a = idx_a + 1;
    #1;
    a_sdata[0] = (idx_a < 14) ? fw_a[13 - idx_a] : 1'b0;
  end

  // Converter model B: three converters sharing CSN/SCLK
  logic [12:0] fw_b [3];
  int          idx_b = 0;
  always @(negedge b_csn or negedge b_sclk) begin
    if (b_sclk) idx_b = 0;
    else        idx_b = idx_b + 1;
    #1;
    for (int c = 0; c < 3; c++) b_sdata[c] = (idx_b < 13) ? fw_b[c][12 - idx_b] : 1'b0;
  end

  // Monitor A: strobe times/data, CSN-low run lengths, SCLK falls per frame
  int          cyc_a = 0;
  int          stbq[$];
  logic [11:0] dq[$];
  logic        eq[$];
  int          lowq[$];
  int          fallq[$];
  int          low_run = 0;
  int          falls = 0;
  logic        prev_csn = 1'b1;
  logic        prev_sclk = 1'b1;
  always @(negedge clk) begin
    cyc_a++;
    if (a_csn === 1'b0) begin
      low_run++;
      if (prev_sclk === 1'b1 && a_sclk === 1'b0) falls++;
    end else if (prev_csn === 1'b0) begin
      lowq.push_back(low_run);
      fallq.push_back(falls);
      low_run = 0;
      falls = 0;
    end
    if (a_data_en === 1'b1) begin
      stbq.push_back(cyc_a);
      dq.push_back(a_data);
      eq.push_back(a_lead_err[0]);
    end
    prev_csn  = a_csn;
    prev_sclk = a_sclk;
  end

  // Monitor B: total strobe count
  int b_stb = 0;
  always @(negedge clk) if (b_data_en === 1'b1) b_stb++;

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    stbq.delete(); dq.delete(); eq.delete(); lowq.delete(); fallq.delete();
  endtask

  task automatic wait_strobes(input int n, input int budget, input string tag);
    int k = 0;
    while (stbq.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    check(tag, 64'(stbq.size()), 64'(n));
  endtask

  task automatic wait_csn_low_a(input string tag);
    int k = 0;
    while (a_csn !== 1'b0 && k < 60) begin
      tick(1);
      k++;
    end
    check(tag, 64'(a_csn), 64'd0);
  endtask

  initial begin
    int n;
    rstn = 1'b0;
    a_cont_en = 1'b0; a_start = 1'b0; b_cont_en = 1'b0; b_start = 1'b0;
    a_sdata = '0; b_sdata = '0;
    fw_a = {2'b00, 12'hA5C};
    fw_b[0] = {3'b000, 10'h3FF};
    fw_b[1] = {3'b000, 10'h001};
    fw_b[2] = {3'b000, 10'h155};
    tick(3);

    // Reset state
    check("rst_csn", 64'(a_csn), 64'd1);
    check("rst_sclk", 64'(a_sclk), 64'd1);
    check("rst_busy", 64'(a_busy), 64'd0);
    check("rst_data_en", 64'(a_data_en), 64'd0);
    check("rst_data", 64'(a_data), 64'd0);
    check("rst_lead_err", 64'(a_lead_err), 64'd0);
    rstn = 1'b1;
    tick(3);
    check("idle_csn", 64'(a_csn), 64'd1);
    check("idle_busy", 64'(a_busy), 64'd0);

    // Continuous conversion, clean frames of 12'hA5C
    clear_mon();
    a_cont_en = 1'b1;
    wait_strobes(3, 150, "cont_strobes");
    for (int i = 0; i < 3; i++) begin
      check($sformatf("cont_data%0d", i), 64'(dq[i]), 64'hA5C);
      check($sformatf("cont_err%0d", i), 64'(eq[i]), 64'd0);
      check($sformatf("cont_csn_low%0d", i), 64'(lowq[i]), 64'd28);
      check($sformatf("cont_falls%0d", i), 64'(fallq[i]), 64'd14);
    end
    check("cont_period01", 64'(stbq[1] - stbq[0]), 64'd32);
    check("cont_period12", 64'(stbq[2] - stbq[1]), 64'd32);

    // Leading bits 01: error flagged, data still delivered
    fw_a = {2'b01, 12'h123};
    clear_mon();
    wait_strobes(1, 60, "lead_strobe");
    check("lead_data", 64'(dq[0]), 64'h123);
    check("lead_err", 64'(eq[0]), 64'd1);

    // cont_en dropped at bit 5: frame completes, then IDLE
    fw_a = {2'b00, 12'h3C5};
    clear_mon();
    wait_csn_low_a("stop_csn_fall");
    tick(9);
    a_cont_en = 1'b0;
    wait_strobes(1, 60, "stop_strobe");
    check("stop_data", 64'(dq[0]), 64'h3C5);
    check("stop_err", 64'(eq[0]), 64'd0);
    tick(10);
    check("stop_count", 64'(stbq.size()), 64'd1);
    check("stop_csn", 64'(a_csn), 64'd1);
    check("stop_sclk", 64'(a_sclk), 64'd1);
    check("stop_busy", 64'(a_busy), 64'd0);

    // Single shot; start pulses in ACTIVE and QUIET ignored
    clear_mon();
    a_start = 1'b1; tick(1); a_start = 1'b0;
    tick(10);
    check("shot_busy", 64'(a_busy), 64'd1);
    a_start = 1'b1; tick(1); a_start = 1'b0;
    wait_strobes(1, 40, "shot_strobe");
    a_start = 1'b1; tick(1); a_start = 1'b0;
    tick(60);
    check("shot_count", 64'(stbq.size()), 64'd1);
    check("shot_data", 64'(dq[0]), 64'h3C5);
    check("shot_busy_end", 64'(a_busy), 64'd0);

    // Asynchronous reset mid-frame (around bit 7)
    fw_a = {2'b00, 12'hA5C};
    a_cont_en = 1'b1;
    wait_csn_low_a("rst_csn_fall");
    tick(13);
    clear_mon();
    #2;
    rstn = 1'b0;
    #1;
    check("mid_rst_csn", 64'(a_csn), 64'd1);
    check("mid_rst_sclk", 64'(a_sclk), 64'd1);
    check("mid_rst_busy", 64'(a_busy), 64'd0);
    check("mid_rst_data_en", 64'(a_data_en), 64'd0);
    check("mid_rst_data", 64'(a_data), 64'd0);
    tick(3);
    check("mid_rst_no_strobe", 64'(stbq.size()), 64'd0);
    clear_mon();
    rstn = 1'b1;
    wait_strobes(1, 80, "post_rst_strobe");
    check("post_rst_data", 64'(dq[0]), 64'hA5C);
    check("post_rst_err", 64'(eq[0]), 64'd0);
    check("post_rst_csn_low", 64'(lowq[0]), 64'd28);
    check("post_rst_falls", 64'(fallq[0]), 64'd14);
    a_cont_en = 1'b0;
    tick(40);

    // Three-channel single shot with SCLK_HALF=2
    b_start = 1'b1; tick(1); b_start = 1'b0;
    n = 0;
    while (b_csn !== 1'b0 && n < 10) begin tick(1); n++; end
    check("b_csn_fall", 64'(b_csn), 64'd0);
    n = 0;
    while (b_data_en !== 1'b1 && n < 100) begin tick(1); n++; end
    check("b_latency", 64'(n), 64'd52);
    check("b_data", 64'(b_data), {34'd0, 10'h155, 10'h001, 10'h3FF});
    check("b_lead_err", 64'(b_lead_err), 64'd0);
    tick(6);
    check("b_busy_idle", 64'(b_busy), 64'd0);
    tick(60);
    check("b_strobe_count", 64'(b_stb), 64'd1);
    check("b_csn_idle", 64'(b_csn), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adc_reader.md
# serial_adc_reader

Parametrised serial SAR-ADC capture engine for AD7276-class converters (CS-framed, data shifted out MSB-first on SCLK falling edges, leading zero bits). It drives a shared CSN/SCLK pair to NUM_CH converters with independent SDATA lines, so multiple converters are captured in lockstep. It supports continuous or single-shot conversion and flags leading-zero framing errors. It sits between the ADC pins and the downstream DSP/filter chain, delivering one parallel word per channel per frame.

## Interface
- DATA_W, 12: result bits per channel (1..16)
- LEAD_BITS, 2: leading zero bits clocked before data, discarded and checked (0..4)
- SCLK_HALF, 1: clk cycles per SCLK half-period (>=1)
- QUIET, 4: clk cycles CSN held high between frames (>=1)
- NUM_CH, 1: number of converters sharing CSN/SCLK (>=1)
- clk  in  1  system clock
- rstn  in  1  reset, asynchronous, active-low
- cont_en  in  1  1 = back-to-back continuous conversion
- start  in  1  single-cycle request for one conversion; honoured only in IDLE
- adc_csn  out  1  chip select to all converters, active-low
- adc_sclk  out  1  serial clock to all converters, idles high
- adc_sdata  in  NUM_CH  serial data, bit c from converter c
- busy  out  1  high whenever state is not IDLE
- adc_data_en  out  1  one-cycle valid strobe for adc_data/lead_err
- adc_data  out  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]
- lead_err  out  NUM_CH  bit c set if any leading bit of channel c read as 1

## Operation
- N = LEAD_BITS + DATA_W SCLK cycles per frame. All outputs are registered.
- States:
  - IDLE: csn=1, sclk=1. Go to ACTIVE when cont_en=1 or start=1.
  - ACTIVE: csn=0. sclk starts high and toggles every SCLK_HALF clk cycles, giving exactly N falling edges. Duration is 2*N*SCLK_HALF clk cycles; the last half-period is sclk low. Then csn and sclk both go high on the same edge, and the block enters QUIET.
  - QUIET: csn=1, sclk=1 for QUIET cycles. Then go to ACTIVE if cont_en=1, else IDLE.
- Sampling: on the clk edge that drives sclk 1->0, adc_sdata is captured for every channel.
  - The first LEAD_BITS captures are OR-ed into per-channel error accumulators.
  - The next DATA_W captures are shifted in MSB-first.
- Delivery: on the edge entering QUIET, load adc_data and lead_err from the shift registers/accumulators and assert adc_data_en for exactly 1 cycle. Data is delivered even when lead_err=1. adc_data and lead_err hold their values until the next delivery.
- Accumulators and shift registers clear on entry to ACTIVE.
- start is ignored in ACTIVE and QUIET, with no queuing. start with cont_en=0 yields exactly one frame.
- cont_en deasserted mid-frame: the current frame completes and delivers, then the block goes to IDLE after QUIET.
- Reset, asynchronous at any point (including mid-frame): csn=1, sclk=1, busy=0, adc_data_en=0, adc_data=0, lead_err=0, state IDLE, all counters 0. A partial frame is never delivered.
- Counter widths are sized by $clog2 of their maximum counts. The bit counter wraps per frame only.

## Timing
- Frame period in continuous mode: 2*N*SCLK_HALF + QUIET clk cycles. Defaults: 28 + 4 = 32, i.e. clk/32 sample rate.
- From start/cont_en sampled high in IDLE, csn falls on the next edge.
- adc_data_en is asserted on the same edge csn rises: 2*N*SCLK_HALF cycles after csn falls.
- busy rises with csn fall and falls on entry to IDLE.
- Bit k of the frame (k = 1..N) is sampled (2k-1)*SCLK_HALF cycles after csn falls.
- The converter's max SCLK constrains the SCLK_HALF choice; that constraint lies outside this block.

## Test plan
- Defaults, cont_en=1, converter model returning 00 + 12'hA5C each frame -> adc_data=12'hA5C, lead_err=0, adc_data_en once every 32 cycles, csn low exactly 28 cycles per frame, 14 sclk falling edges.
- NUM_CH=3, DATA_W=10, LEAD_BITS=3, SCLK_HALF=2, single start pulse, channels return 10'h3FF / 10'h001 / 10'h155 -> one strobe after 52 cycles, adc_data={10'h155,10'h001,10'h3FF}, busy low after QUIET, no further frames.
- Channel 0 drives leading bits 01 -> lead_err=1'b1, data still delivered and correct.
- Pulse start while ACTIVE and during QUIET with cont_en=0 -> ignored, exactly one frame total.
- Deassert cont_en at bit 5 of a frame -> that frame delivers, then IDLE with csn=1, sclk=1.
- Assert rstn=0 mid-frame (bit 7) -> csn/sclk immediately 1, no adc_data_en, adc_data=0. After release with cont_en=1, a clean full frame is delivered.
